// File: rtl/round_robin_arbiter_with_hold.sv
// Round-robin arbiter that lets a winner keep its grant for several cycles.
// An owner gives up the grant when it drops its request, signals last, or
// reaches MAX_HOLD cycles. After a release the pointer moves past the old
// owner, so a releasing owner that still requests has the lowest priority.
// A new winner is granted on the same edge as the release, with no idle cycle.
module round_robin_arbiter_with_hold #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   input  logic                 last,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_id,
   output logic                 busy
);

   localparam int IW = $clog2(N);
   localparam int HW = $clog2(MAX_HOLD + 1);

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [IW-1:0]  ptr_q, ptr_d;
   logic [HW-1:0]  hold_q, hold_d;
   logic [N-1:0]   grant_d;
   logic [IW-1:0]  id_d;

   logic [IW-1:0]  next_ptr;
   logic [IW-1:0]  base;
   logic [IW-1:0]  cand;
   logic [IW-1:0]  win_idx;
   logic           win_found;
   logic           release_now;

   // Decide whether the owner lets go this edge, and pick the pointer to scan from
   always_comb begin
      release_now = 1'b0;
      next_ptr    = IW'((int'(grant_id) + 1) % N);
      if (state_q == OWN) begin
         release_now = !req[grant_id] || last || (hold_q == HW'(MAX_HOLD - 1));
      end
      base = (state_q == OWN) ? next_ptr : ptr_q;
   end

   // Scan requests starting at base and wrapping round; first set bit wins
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < N; k++) begin
         cand = IW'((int'(base) + k) % N);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Next-state logic: take ownership, hold it, or hand it over on release
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      grant_d = grant;
      id_d    = grant_id;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d          = OWN;
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               id_d             = win_idx;
               hold_d           = '0;
            end
         end
         OWN: begin
            if (release_now) begin
               ptr_d = next_ptr;
               if (win_found) begin
                  grant_d          = '0;
                  grant_d[win_idx] = 1'b1;
                  id_d             = win_idx;
                  hold_d           = '0;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
                  id_d    = '0;
                  hold_d  = '0;
               end
            end else if (hold_q != {HW{1'b1}}) begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            id_d    = '0;
            hold_d  = '0;
         end
      endcase
   end

   // State register; reset drops any grant at once and leaves the pointer at 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         hold_q   <= '0;
         grant    <= '0;
         grant_id <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         hold_q   <= hold_d;
         grant    <= grant_d;
         grant_id <= id_d;
      end
   end

   assign busy = |grant;

endmodule

// File: tb/tb_round_robin_arbiter_with_hold.sv
// Directed bench for round_robin_arbiter_with_hold with N=4 and MAX_HOLD=4.
module tb_round_robin_arbiter_with_hold;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic       last;
   logic [3:0] grant;
   logic [1:0] grant_id;
   logic       busy;

   int checks;
   int failures;

   round_robin_arbiter_with_hold #(
      .N(4),
      .MAX_HOLD(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req(req),
      .last(last),
      .grant(grant),
      .grant_id(grant_id),
      .busy(busy)
   );

   // Free-running 10ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle 1ns past it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 4'b0000;
      last  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = 4'b1111;
      last  = 1'b0;
      repeat (2) step();
      checks++;
      if (grant !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL reset_grant got=%b expected=%b", grant, 4'b0000);
      end
      checks++;
      if (grant_id !== 2'd0) begin
         failures++;
         $display("[TB] FAIL reset_grant_id got=%0d expected=%0d", grant_id, 0);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_busy got=%b expected=%b", busy, 1'b0);
      end
   endtask

   task automatic test_first_grant();
      do_reset();
      req = 4'b1010;
      step();
      checks++;
      if (grant !== 4'b0010) begin
         failures++;
         $display("[TB] FAIL first_grant got=%b expected=%b", grant, 4'b0010);
      end
      checks++;
      if (grant_id !== 2'd1) begin
         failures++;
         $display("[TB] FAIL first_grant_id got=%0d expected=%0d", grant_id, 1);
      end
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL first_busy got=%b expected=%b", busy, 1'b1);
      end
   endtask

   task automatic test_last_handoff();
      // owner 1 already holds from test_first_grant with req=1010
      last = 1'b1;
      step();
      last = 1'b0;
      checks++;
      if (grant !== 4'b1000) begin
         failures++;
         $display("[TB] FAIL last_handoff got=%b expected=%b", grant, 4'b1000);
      end
      checks++;
      if (grant_id !== 2'd3) begin
         failures++;
         $display("[TB] FAIL last_handoff_id got=%0d expected=%0d", grant_id, 3);
      end
      // non-owner request changes must not disturb the current owner
      req = 4'b1011;
      step();
      checks++;
      if (grant !== 4'b1000) begin
         failures++;
         $display("[TB] FAIL hold_nonowner got=%b expected=%b", grant, 4'b1000);
      end
   endtask

   task automatic test_rotation();
      logic [3:0] exp_grant;
      logic [1:0] exp_id;
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < 17; i++) begin
         step();
         exp_id    = 2'((i / 4) % 4);
         exp_grant = 4'b0001 << exp_id;
         checks++;
         if (grant !== exp_grant) begin
            failures++;
            $display("[TB] FAIL rotation cycle %0d got=%b expected=%b", i, grant, exp_grant);
         end
         checks++;
         if (grant_id !== exp_id) begin
            failures++;
            $display("[TB] FAIL rotation_id cycle %0d got=%0d expected=%0d", i, grant_id, exp_id);
         end
      end
   endtask

   task automatic test_single_requester();
      do_reset();
      req = 4'b0001;
      for (int i = 0; i < 12; i++) begin
         step();
         checks++;
         if (grant !== 4'b0001 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_req cycle %0d got grant=%b busy=%b expected grant=%b busy=%b",
                     i, grant, busy, 4'b0001, 1'b1);
         end
      end
   endtask

   task automatic test_drop_to_idle();
      do_reset();
      req = 4'b0100;
      step();
      checks++;
      if (grant !== 4'b0100) begin
         failures++;
         $display("[TB] FAIL drop_setup got=%b expected=%b", grant, 4'b0100);
      end
      req = 4'b0000;
      step();
      checks++;
      if (grant !== 4'b0000 || busy !== 1'b0 || grant_id !== 2'd0) begin
         failures++;
         $display("[TB] FAIL drop_idle got grant=%b busy=%b id=%0d expected grant=%b busy=%b id=%0d",
                  grant, busy, grant_id, 4'b0000, 1'b0, 0);
      end
      // pointer now sits at 3, so requester 3 beats requester 0
      req = 4'b1001;
      step();
      checks++;
      if (grant !== 4'b1000) begin
         failures++;
         $display("[TB] FAIL drop_ptr got=%b expected=%b", grant, 4'b1000);
      end
   endtask

   task automatic test_simultaneous_release();
      do_reset();
      req = 4'b0011;
      step();
      checks++;
      if (grant !== 4'b0001) begin
         failures++;
         $display("[TB] FAIL simul_setup got=%b expected=%b", grant, 4'b0001);
      end
      req  = 4'b0010;
      last = 1'b1;
      step();
      last = 1'b0;
      checks++;
      if (grant !== 4'b0010) begin
         failures++;
         $display("[TB] FAIL simul_release got=%b expected=%b", grant, 4'b0010);
      end
      step();
      checks++;
      if (grant !== 4'b0010) begin
         failures++;
         $display("[TB] FAIL simul_hold got=%b expected=%b", grant, 4'b0010);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 4'b0100;
      step();
      checks++;
      if (grant !== 4'b0100) begin
         failures++;
         $display("[TB] FAIL areset_setup got=%b expected=%b", grant, 4'b0100);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (grant !== 4'b0000 || busy !== 1'b0 || grant_id !== 2'd0) begin
         failures++;
         $display("[TB] FAIL areset_immediate got grant=%b busy=%b id=%0d expected grant=%b busy=%b id=%0d",
                  grant, busy, grant_id, 4'b0000, 1'b0, 0);
      end
      step();
      req   = 4'b1001;
      rst_n = 1'b1;
      step();
      checks++;
      if (grant !== 4'b0001) begin
         failures++;
         $display("[TB] FAIL areset_after got=%b expected=%b", grant, 4'b0001);
      end
   endtask

   // Run every scenario in order, then report
   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      req      = 4'b0000;
      last     = 1'b0;
      test_reset();
      test_first_grant();
      test_last_handoff();
      test_rotation();
      test_single_requester();
      test_drop_to_idle();
      test_simultaneous_release();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/round_robin_arbiter_with_hold.md
ROUND_ROBIN_ARBITER_WITH_HOLD -- requirements
Module: round_robin_arbiter_with_hold

Interface
REQ-001 The block SHALL have parameter N, default 4: number of requesters, N >= 2.
REQ-002 The block SHALL have parameter MAX_HOLD, default 8: maximum consecutive grant cycles per ownership, MAX_HOLD >= 1.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port req  input  N  request per requester; bit i = requester i.
REQ-006 The block SHALL have port last  input  1  current owner marks its final granted cycle; ignored when no owner.
REQ-007 The block SHALL have port grant  output  N  registered one-hot grant, or all-zero when idle.
REQ-008 The block SHALL have port grant_id  output  $clog2(N)  index of the current owner, 0 when idle.
REQ-009 The block SHALL have port busy  output  1  equals OR of grant.

Function
REQ-010 The block SHALL implement two states: IDLE (no owner) and OWN (one owner).
REQ-011 The block SHALL keep a priority pointer ptr in range 0..N-1; the arbitration winner is the first set req bit scanning ptr, ptr+1, ..., wrapping modulo N.
REQ-012 In IDLE with req != 0 at a rising edge, the block SHALL load grant with the one-hot winner at that edge (one-cycle latency), enter OWN, and clear hold_cnt to 0.
REQ-013 In IDLE with req == 0, the block SHALL keep grant = 0 and ptr unchanged.
REQ-014 In OWN, hold_cnt SHALL increment once per cycle that the grant is held, with saturating width $clog2(MAX_HOLD+1).
REQ-015 In OWN, a release SHALL occur at an edge when any of the following holds: req[owner] == 0, last == 1, or hold_cnt == MAX_HOLD-1.
REQ-016 On release, ptr SHALL become (owner+1) mod N, and arbitration SHALL run with that updated ptr at the same edge.
REQ-017 At release, if a winner exists, the new grant SHALL be loaded at that same edge with no idle bubble, and hold_cnt SHALL clear to 0.
REQ-018 At release with no winner, the block SHALL set grant to 0 and return to IDLE.
REQ-019 A releasing owner that still requests SHALL have the lowest priority, and SHALL be re-granted only if no other requester is active.
REQ-020 In OWN without release, changes on non-owner req bits SHALL not affect grant.
REQ-021 In OWN without release, the owner and ptr SHALL be held.
REQ-022 Simultaneous last and req[owner] drop SHALL be treated as a single release.
REQ-023 grant SHALL never have more than one bit set.
REQ-024 grant_id and busy SHALL always be consistent with grant.

Reset
REQ-025 While rst_n == 0, the block SHALL immediately clear grant and grant_id, and SHALL clear busy to 0, without waiting for clk.
REQ-026 While rst_n == 0, the block SHALL hold ptr = 0, hold_cnt = 0 and state = IDLE.
REQ-027 An assertion of rst_n mid-ownership SHALL abort the grant without a pointer update.
REQ-028 The first arbitration after rst_n deasserts SHALL use ptr = 0.

Verification (N=4, MAX_HOLD=4)
REQ-029 The bench SHALL cover: after reset, req=1010 -> at next edge grant=0010, grant_id=1, busy=1.
REQ-030 The bench SHALL cover: owner 1 holding with req=1010, last=1 for one cycle -> next edge grant=1000 with no zero cycle; ptr=2.
REQ-031 The bench SHALL cover: req=1111 held with last=0 -> grant sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001 again.
REQ-032 The bench SHALL cover: only req[0] held continuously -> grant=0001 on every cycle, with hold_cnt wrapping 0..3 and re-grant at each timeout.
REQ-033 The bench SHALL cover: owner 2 drops req with all other req=0 -> next edge grant=0000, busy=0, state IDLE, ptr=3.
REQ-034 The bench SHALL cover: rst_n pulsed low between clock edges while grant=0100 -> grant=0000 immediately; after release, req=1001 -> grant=0001.
